nios_debug_jtag_host: RTL and testbench
=======================================

Name: nios_debug_jtag_host

Overview:
JTAG-side initiator for the Nios II virtual-JTAG debug slave. It drives the virtual-JTAG interface signals that the slave's tck-domain logic consumes: ir_in, uir/cdr/sdr/udr strobes, rti, tck and tdi. It also captures tdo. It lets on-chip logic or a bench issue debug-slave IR/DR transactions from the system clock. Each transaction is one 2-bit IR update followed by a DR_WIDTH-bit capture/shift/update, and it returns the shifted-out data.

Parameters:
DR_WIDTH, 38, data-register length in bits; matches the debug-slave jdo/sr width.
CLK_DIV, 2, clk cycles per tck half-period; legal values are 1 or more.
IR_WIDTH, 2, virtual IR width.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
reset  in  1  synchronous active-high reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  block can accept a command.
cmd_ir  in  IR_WIDTH  IR value to load.
cmd_data  in  DR_WIDTH  DR value to shift in, LSB first.
resp_valid  out  1  captured DR is valid.
resp_ready  in  1  response consumed.
resp_data  out  DR_WIDTH  DR value shifted out of the slave.
tck  out  1  generated JTAG clock.
tdi  out  1  serial data to the slave.
tdo  in  1  serial data from the slave.
ir_in  out  IR_WIDTH  virtual IR presented to the slave.
vs_uir  out  1  update-IR state indicator.
vs_cdr  out  1  capture-DR state indicator.
vs_sdr  out  1  shift-DR state indicator.
vs_udr  out  1  update-DR state indicator.
jtag_state_rti  out  1  run-test-idle indicator.

Behaviour:
- Reset values:
  - All outputs are 0, except cmd_ready=1 and jtag_state_rti=1.
  - resp_data=0 and the shift register is 0.
  - The FSM is in IDLE and the half-period counter is 0.
- Reset mid-transaction:
  - Outputs return to reset values on the next edge.
  - The transaction is abandoned and no response is produced.
- tck generation:
  - Outside IDLE/RESP, tck toggles every CLK_DIV clk cycles, starting low.
  - One tck period is 2*CLK_DIV clk cycles. tck is held at 0 in IDLE/RESP.
- Data timing:
  - tdi changes only on tck falling transitions (and on state entry).
  - tdo is sampled on the clk edge that drives tck high.
- FSM states: IDLE, UIR, CDR, SDR, UDR, RTI, RESP. Each state lasts exactly one tck period, except SDR, which lasts DR_WIDTH periods.
- IDLE:
  - cmd_ready=1 and jtag_state_rti=1.
  - On cmd_valid&&cmd_ready: latch cmd_ir to ir_in, load shift register sr with cmd_data, move to UIR. cmd_ready drops on the following cycle.
- UIR: vs_uir=1. ir_in keeps the new value and holds it until the next accepted command.
- CDR: vs_cdr=1 and tdi=sr[0].
- SDR:
  - vs_sdr=1 and tdi=sr[0].
  - On each tck rising sample: sr <= {tdo, sr[DR_WIDTH-1:1]} and the bit counter increments.
  - Exit after the DR_WIDTH-th sample completes its period.
- UDR: vs_udr=1 and tdi=0.
- RTI: jtag_state_rti=1.
- RESP:
  - resp_valid=1 and resp_data=sr. resp_data is registered at RTI exit and held stable while resp_valid.
  - cmd_ready=0. Go to IDLE on resp_ready.
- Exclusivity: exactly one of vs_uir/vs_cdr/vs_sdr/vs_udr/jtag_state_rti is high outside IDLE/RESP. None of the vs_* strobes is high in IDLE/RESP.
- Latency: resp_valid rises exactly (DR_WIDTH+4)*2*CLK_DIV clk cycles after the accepting edge. With defaults this is 168.
- Back-to-back operation:
  - resp_ready is accepted in the same cycle resp_valid first asserts.
  - cmd_ready reasserts on the cycle after the response handshake; there is no zero-bubble overlap.
  - cmd_valid during RESP is not accepted.
- Counters:
  - The half-period counter width is clog2(CLK_DIV)+1 and it wraps to 0 at CLK_DIV-1.
  - The bit counter width is clog2(DR_WIDTH)+1 and it is cleared on CDR entry.

Test Plan:
1. Reset → defaults: assert reset 2 cycles → cmd_ready=1, resp_valid=0, tck=0, ir_in=0, jtag_state_rti=1, all vs_*=0.
2. Single transaction with loopback: bench slave model loads sr=38'h2A_1234_5678 on cdr and shifts on tck rise. Send cmd_ir=2'b01, cmd_data=38'h15_DEAD_BEEF → resp_data=38'h2A_1234_5678 after exactly 168 cycles; the slave sees 38'h15_DEAD_BEEF at udr; ir_in=2'b01 during uir.
3. Strobe sequence and timing: record strobes → uir, cdr, sdr×38, udr, rti in order. Each non-SDR strobe is 4 clk wide; vs_sdr is 152 clk wide; tdi is stable across every tck rise.
4. Response backpressure: hold resp_ready=0 for 20 cycles → resp_valid and resp_data stay stable, cmd_ready=0, cmd_valid ignored. Raise resp_ready → cmd_ready=1 on the next cycle.
5. Reset mid-shift: assert reset at the 10th SDR bit → next edge gives all outputs at reset values and no resp_valid. A new command then completes normally with correct data.
6. CLK_DIV=1 build: repeat scenario 2 → latency 84 cycles and tck period of 2 clk cycles.

Source files
------------

// File: rtl/nios_debug_jtag_host.sv
// JTAG-side initiator for the Nios II virtual-JTAG debug slave.
// Each accepted command performs one IR update followed by a full
// capture/shift/update of a DR_WIDTH-bit data register. It then presents the
// bits shifted out of the slave as a response.
module nios_debug_jtag_host #(
   parameter int DR_WIDTH = 38,
   parameter int CLK_DIV  = 2,
   parameter int IR_WIDTH = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_data,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DR_WIDTH-1:0] resp_data,
   output logic                tck,
   output logic                tdi,
   input  logic                tdo,
   output logic [IR_WIDTH-1:0] ir_in,
   output logic                vs_uir,
   output logic                vs_cdr,
   output logic                vs_sdr,
   output logic                vs_udr,
   output logic                jtag_state_rti
);

   localparam int HC_W = $clog2(CLK_DIV) + 1;
   localparam int BC_W = $clog2(DR_WIDTH) + 1;
   localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DR_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RESP
   } state_t;

   state_t              r_state;
   logic [HC_W-1:0]     r_hcnt;
   logic [BC_W-1:0]     r_bcnt;
   logic [DR_WIDTH-1:0] r_sr;
   logic                r_cmd_ready;
   logic                r_resp_valid;
   logic [DR_WIDTH-1:0] r_resp_data;
   logic                r_tck;
   logic                r_tdi;
   logic [IR_WIDTH-1:0] r_ir_in;
   logic                r_uir;
   logic                r_cdr;
   logic                r_sdr;
   logic                r_udr;
   logic                r_rti;

   logic w_half_end;
   logic w_rise;
   logic w_fall;

   // A half tck period ends on the last count. Which tck edge that is depends on the current tck level.
   assign w_half_end = (r_hcnt == HC_LAST);
   assign w_rise     = w_half_end && !r_tck;
   assign w_fall     = w_half_end &&  r_tck;

   assign cmd_ready      = r_cmd_ready;
   assign resp_valid     = r_resp_valid;
   assign resp_data      = r_resp_data;
   assign tck            = r_tck;
   assign tdi            = r_tdi;
   assign ir_in          = r_ir_in;
   assign vs_uir         = r_uir;
   assign vs_cdr         = r_cdr;
   assign vs_sdr         = r_sdr;
   assign vs_udr         = r_udr;
   assign jtag_state_rti = r_rti;

   // Transaction sequencer: tck generation, TAP-state strobes, DR shifting and the response handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_hcnt       <= '0;
         r_bcnt       <= '0;
         r_sr         <= '0;
         r_cmd_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_data  <= '0;
         r_tck        <= 1'b0;
         r_tdi        <= 1'b0;
         r_ir_in      <= '0;
         r_uir        <= 1'b0;
         r_cdr        <= 1'b0;
         r_sdr        <= 1'b0;
         r_udr        <= 1'b0;
         r_rti        <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid && r_cmd_ready) begin
                  r_ir_in     <= cmd_ir;
                  r_sr        <= cmd_data;
                  r_cmd_ready <= 1'b0;
                  r_rti       <= 1'b0;
                  r_uir       <= 1'b1;
                  r_hcnt      <= '0;
                  r_tck       <= 1'b0;
                  r_tdi       <= 1'b0;
                  r_state     <= S_UIR;
               end
            end
            S_RESP: begin
               // The TAP rests in idle again only once the response has been taken.
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_cmd_ready  <= 1'b1;
                  r_rti        <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
            default: begin
               r_hcnt <= w_half_end ? '0 : r_hcnt + HC_W'(1);
               if (w_half_end) begin
                  r_tck <= ~r_tck;
               end
               // The slave drives tdo on falling tck, so tdo is stable when the host samples it on the rising edge.
               if (w_rise && (r_state == S_SDR)) begin
                  r_sr   <= {tdo, r_sr[DR_WIDTH-1:1]};
                  r_bcnt <= r_bcnt + BC_W'(1);
               end
               // State changes happen on the falling edge. That edge is where each tck period ends.
               if (w_fall) begin
                  case (r_state)
                     S_UIR: begin
                        r_uir   <= 1'b0;
                        r_cdr   <= 1'b1;
                        r_tdi   <= r_sr[0];
                        r_bcnt  <= '0;
                        r_state <= S_CDR;
                     end
                     S_CDR: begin
                        r_cdr   <= 1'b0;
                        r_sdr   <= 1'b1;
                        r_tdi   <= r_sr[0];
                        r_state <= S_SDR;
                     end
                     S_SDR: begin
                        if (r_bcnt == BC_LAST) begin
                           r_sdr   <= 1'b0;
                           r_udr   <= 1'b1;
                           r_tdi   <= 1'b0;
                           r_state <= S_UDR;
                        end else begin
                           r_tdi <= r_sr[0];
                        end
                     end
                     S_UDR: begin
                        r_udr   <= 1'b0;
                        r_rti   <= 1'b1;
                        r_state <= S_RTI;
                     end
                     S_RTI: begin
                        r_rti        <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= r_sr;
                        r_state      <= S_RESP;
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nios_debug_jtag_host.sv
// Bench for nios_debug_jtag_host. A behavioural virtual-JTAG slave loads a
// capture word, exchanges bits on tck rise and records what it receives at
// update-DR. Two instances are built: the default divider, and CLK_DIV=1.
module tb_nios_debug_jtag_host;

   localparam int DW  = 38;
   localparam int IW  = 2;
   localparam int CD0 = 2;
   localparam int CD1 = 1;

   logic clk = 1'b0;
   logic reset = 1'b1;

   // instance 0 (CLK_DIV = 2)
   logic          cmd_valid = 1'b0, cmd_ready, resp_valid, resp_ready = 1'b0;
   logic [IW-1:0] cmd_ir = '0, ir_in;
   logic [DW-1:0] cmd_data = '0, resp_data;
   logic          tck, tdi, tdo, vs_uir, vs_cdr, vs_sdr, vs_udr, rti;

   // instance 1 (CLK_DIV = 1)
   logic          cmd_valid1 = 1'b0, cmd_ready1, resp_valid1, resp_ready1 = 1'b0;
   logic [IW-1:0] ir_in1;
   logic [DW-1:0] resp_data1;
   logic          tck1, tdi1, tdo1, vs_uir1, vs_cdr1, vs_sdr1, vs_udr1, rti1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   nios_debug_jtag_host #(.DR_WIDTH(DW), .CLK_DIV(CD0), .IR_WIDTH(IW)) u_dut0 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ir(cmd_ir), .cmd_data(cmd_data), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_data(resp_data), .tck(tck), .tdi(tdi),
      .tdo(tdo), .ir_in(ir_in), .vs_uir(vs_uir), .vs_cdr(vs_cdr),
      .vs_sdr(vs_sdr), .vs_udr(vs_udr), .jtag_state_rti(rti));

   nios_debug_jtag_host #(.DR_WIDTH(DW), .CLK_DIV(CD1), .IR_WIDTH(IW)) u_dut1 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
      .cmd_ir(cmd_ir), .cmd_data(cmd_data), .resp_valid(resp_valid1),
      .resp_ready(resp_ready1), .resp_data(resp_data1), .tck(tck1), .tdi(tdi1),
      .tdo(tdo1), .ir_in(ir_in1), .vs_uir(vs_uir1), .vs_cdr(vs_cdr1),
      .vs_sdr(vs_sdr1), .vs_udr(vs_udr1), .jtag_state_rti(rti1));

   // Slave models: capture on cdr, shift on sdr, record on udr/uir (all on tck rise).
   logic [DW-1:0] s0_sr = '0, s0_cap = '0, s0_udr = '0;
   logic [IW-1:0] s0_ir = '0;
   logic [DW-1:0] s1_sr = '0, s1_cap = '0, s1_udr = '0;
   assign tdo  = s0_sr[0];
   assign tdo1 = s1_sr[0];

   always @(posedge tck) begin
      if (vs_cdr)      s0_sr <= s0_cap;
      else if (vs_sdr) s0_sr <= {tdi, s0_sr[DW-1:1]};
      if (vs_udr)      s0_udr <= s0_sr;
      if (vs_uir)      s0_ir <= ir_in;
   end

   always @(posedge tck1) begin
      if (vs_cdr1)      s1_sr <= s1_cap;
      else if (vs_sdr1) s1_sr <= {tdi1, s1_sr[DW-1:1]};
      if (vs_udr1)      s1_udr <= s1_sr;
   end

   // Strobe-run recorder and tdi/tck monitor for instance 0, sampled mid-cycle.
   bit   rec = 1'b0;
   int   run_code[$];
   int   run_len[$];
   int   onehot_err = 0;
   int   tdi_err = 0;
   int   sdr_rises = 0;
   logic prev_tck = 1'b0;
   logic prev_tdi = 1'b0;
   always @(negedge clk) begin
      int n;
      int code;
      n = int'(vs_uir) + int'(vs_cdr) + int'(vs_sdr) + int'(vs_udr) + int'(rti);
      code = vs_uir ? 1 : vs_cdr ? 2 : vs_sdr ? 3 : vs_udr ? 4 : rti ? 5 : 0;
      if (rec) begin
         if (n != 1) onehot_err++;
         if (run_code.size() == 0 || run_code[run_code.size()-1] != code) begin
            run_code.push_back(code);
            run_len.push_back(1);
         end else begin
            run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
         end
         if (tck && !prev_tck && tdi !== prev_tdi) tdi_err++;
      end
      if (tck && !prev_tck && vs_sdr) sdr_rises++;
      prev_tck = tck;
      prev_tdi = tdi;
   end

   // One full transaction on instance 0, with 'hold' cycles of response backpressure.
   task automatic run0(input logic [IW-1:0] ir, input logic [DW-1:0] data,
                       input logic [DW-1:0] cap, input int hold, input string tag);
      int lat;
      logic [DW-1:0] held;
      s0_cap = cap; cmd_ir = ir; cmd_data = data; cmd_valid = 1'b1; resp_ready = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++; $display("FAIL %s cmd_ready_drop got %b want 0", tag, cmd_ready);
      end
      rec = 1'b1;
      lat = 0;
      while (resp_valid !== 1'b1 && lat < 1000) begin
         @(posedge clk); #1; lat++;
      end
      rec = 1'b0;
      checks++;
      if (lat != (DW + 4) * 2 * CD0) begin
         errors++; $display("FAIL %s latency got %0d want %0d", tag, lat, (DW + 4) * 2 * CD0);
      end
      checks++;
      if (resp_data !== cap) begin
         errors++; $display("FAIL %s resp_data got %h want %h", tag, resp_data, cap);
      end
      checks++;
      if (s0_udr !== data) begin
         errors++; $display("FAIL %s slave_udr got %h want %h", tag, s0_udr, data);
      end
      checks++;
      if (s0_ir !== ir) begin
         errors++; $display("FAIL %s ir_at_uir got %h want %h", tag, s0_ir, ir);
      end
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++; $display("FAIL %s cmd_ready_in_resp got %b want 0", tag, cmd_ready);
      end
      held = resp_data;
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         checks++;
         if (resp_valid !== 1'b1 || resp_data !== cap || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s backpressure cyc %0d got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
                     tag, i, resp_valid, resp_data, cmd_ready, held);
         end
      end
      cmd_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || cmd_ready !== 1'b1 || ir_in !== ir) begin
         errors++;
         $display("FAIL %s handshake got v=%b rdy=%b ir=%h want v=0 rdy=1 ir=%h",
                  tag, resp_valid, cmd_ready, ir_in, ir);
      end
      @(posedge clk); #1;
      checks++;
      if (vs_uir !== 1'b0 || rti !== 1'b1 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s idle_after got uir=%b rti=%b rdy=%b want 0 1 1", tag, vs_uir, rti, cmd_ready);
      end
      $display("txn %s ir=%0h data=%h resp=%h lat=%0d hold=%0d", tag, ir, data, resp_data, lat, hold);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({cmd_ready, resp_valid, tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, rti} !== 11'b100_0_00_0000_1) begin
         errors++;
         $display("FAIL reset_outputs0 got %b want 10000000001",
                  {cmd_ready, resp_valid, tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, rti});
      end
      checks++;
      if (resp_data !== '0) begin
         errors++; $display("FAIL reset_resp_data got %h want 0", resp_data);
      end
      checks++;
      if ({cmd_ready1, resp_valid1, tck1, tdi1, ir_in1, vs_uir1, vs_cdr1, vs_sdr1, vs_udr1, rti1} !== 11'b100_0_00_0000_1) begin
         errors++;
         $display("FAIL reset_outputs1 got %b want 10000000001",
                  {cmd_ready1, resp_valid1, tck1, tdi1, ir_in1, vs_uir1, vs_cdr1, vs_sdr1, vs_udr1, rti1});
      end
      reset = 1'b0;
      @(posedge clk); #1;
      $display("txn reset done");
   endtask

   task automatic test_single();
      run0(2'b01, 38'h15_DEAD_BEEF, 38'h2A_1234_5678, 0, "single");
   endtask

   task automatic test_strobes();
      int exp_code[5] = '{1, 2, 3, 4, 5};
      int exp_len[5];
      logic [DW-1:0] d;
      logic [DW-1:0] c;
      for (int i = 0; i < 5; i++) exp_len[i] = 2 * CD0;
      exp_len[2] = DW * 2 * CD0;
      run_code.delete(); run_len.delete();
      onehot_err = 0; tdi_err = 0; sdr_rises = 0;
      d = DW'({$urandom(), $urandom()});
      c = DW'({$urandom(), $urandom()});
      run0(2'($urandom_range(0, 3)), d, c, 0, "strobes");
      checks++;
      if (run_code.size() != 5) begin
         errors++; $display("FAIL strobe_runs got %0d want 5", run_code.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (run_code[i] != exp_code[i] || run_len[i] != exp_len[i]) begin
               errors++;
               $display("FAIL strobe_run%0d got code=%0d len=%0d want code=%0d len=%0d",
                        i, run_code[i], run_len[i], exp_code[i], exp_len[i]);
            end
         end
      end
      checks++;
      if (sdr_rises != DW) begin
         errors++; $display("FAIL sdr_bits got %0d want %0d", sdr_rises, DW);
      end
      checks++;
      if (tdi_err != 0 || onehot_err != 0) begin
         errors++; $display("FAIL tdi_onehot got tdi_err=%0d onehot_err=%0d want 0 0", tdi_err, onehot_err);
      end
   endtask

   task automatic test_backpressure();
      run0(2'b10, DW'({$urandom(), $urandom()}), DW'({$urandom(), $urandom()}), 20, "backpressure");
   endtask

   task automatic test_reset_mid();
      int guard;
      int seen;
      s0_cap = DW'({$urandom(), $urandom()});
      cmd_ir = 2'b11; cmd_data = DW'({$urandom(), $urandom()}); cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      sdr_rises = 0;
      guard = 0;
      while (sdr_rises < 10 && guard < 500) begin
         @(posedge clk); #1; guard++;
      end
      checks++;
      if (sdr_rises != 10 || vs_sdr !== 1'b1) begin
         errors++; $display("FAIL midreset_reach got bits=%0d sdr=%b want 10 1", sdr_rises, vs_sdr);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({cmd_ready, resp_valid, tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, rti} !== 11'b100_0_00_0000_1) begin
         errors++;
         $display("FAIL midreset_outputs got %b want 10000000001",
                  {cmd_ready, resp_valid, tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, rti});
      end
      checks++;
      if (resp_data !== '0) begin
         errors++; $display("FAIL midreset_resp_data got %h want 0", resp_data);
      end
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (resp_valid !== 1'b0 || vs_sdr !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL midreset_abandon got %0d active cycles want 0", seen);
      end
      $display("txn midreset abandoned");
      run0(2'b01, DW'({$urandom(), $urandom()}), DW'({$urandom(), $urandom()}), 0, "after_reset");
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 5; t++) begin
         run0(2'($urandom_range(0, 3)), DW'({$urandom(), $urandom()}),
              DW'({$urandom(), $urandom()}), int'($urandom_range(0, 3)), "b2b");
      end
   endtask

   task automatic test_clkdiv1();
      for (int t = 0; t < 2; t++) begin
         int lat;
         int rises;
         int nalt;
         logic prev;
         logic [DW-1:0] d;
         logic [DW-1:0] c;
         d = DW'({$urandom(), $urandom()});
         c = DW'({$urandom(), $urandom()});
         s1_cap = c; cmd_data = d; cmd_ir = 2'($urandom_range(0, 3)); cmd_valid1 = 1'b1;
         @(posedge clk); #1;
         cmd_valid1 = 1'b0;
         lat = 0; rises = 0; nalt = 0; prev = tck1;
         while (resp_valid1 !== 1'b1 && lat < 1000) begin
            @(posedge clk); #1; lat++;
            if (tck1 === prev) nalt++;
            if (tck1 && !prev) rises++;
            prev = tck1;
         end
         checks++;
         if (lat != (DW + 4) * 2 * CD1) begin
            errors++; $display("FAIL div1_latency got %0d want %0d", lat, (DW + 4) * 2 * CD1);
         end
         checks++;
         if (rises != DW + 4 || nalt != 0) begin
            errors++; $display("FAIL div1_tck got rises=%0d stalls=%0d want %0d 0", rises, nalt, DW + 4);
         end
         checks++;
         if (resp_data1 !== c || s1_udr !== d) begin
            errors++; $display("FAIL div1_data got resp=%h udr=%h want %h %h", resp_data1, s1_udr, c, d);
         end
         resp_ready1 = 1'b1;
         @(posedge clk); #1;
         resp_ready1 = 1'b0;
         checks++;
         if (resp_valid1 !== 1'b0 || cmd_ready1 !== 1'b1) begin
            errors++; $display("FAIL div1_handshake got v=%b rdy=%b want 0 1", resp_valid1, cmd_ready1);
         end
         $display("txn div1 data=%h resp=%h lat=%0d", d, resp_data1, lat);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_strobes();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_clkdiv1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
